// File: rtl/itf_pkg.sv
// itf_pkg: shared definitions for the off-chip interface arbiter.
//   - itf_state_t : transfer FSM encoding (IDLE=0, CMD=1, IN2CHIP=2, OUT2OFF=3)
//   - DIR_BIT / ADDR_LSB / NUM_LSB : field offsets of the command word on the pad
//   - DEF_* : default width constants
//   - idx_width() : index width for an N-entry vector (at least 1 bit)
package itf_pkg;

  localparam int unsigned DEF_NUM_REQ         = 4;
  localparam int unsigned DEF_PORT_WIDTH      = 128;
  localparam int unsigned DEF_DRAM_ADDR_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH      = 16;

  localparam int unsigned DIR_BIT  = 0;
  localparam int unsigned ADDR_LSB = 1;
  localparam int unsigned NUM_LSB  = 33;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_IN2CHIP = 2'd2,
    ST_OUT2OFF = 2'd3
  } itf_state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   i_req  : request vector
//   i_ptr  : highest-priority index for this decision (0..NUM_REQ-1)
//   o_vld  : at least one request present
//   o_gnt  : one-hot grant
//   o_idx  : index of the granted requester
module rr_arbiter import itf_pkg::*; #(
  parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic               o_vld,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_idx
);

  // Scan from i_ptr upwards, wrapping modulo NUM_REQ; first hit wins.
  always_comb begin
    int unsigned sum;
    logic [IW-1:0] cand;
    o_vld = 1'b0;
    o_gnt = '0;
    o_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = 32'(i_ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = IW'(sum);
      if (!o_vld && i_req[cand]) begin
        o_vld       = 1'b1;
        o_gnt[cand] = 1'b1;
        o_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/itf_arbiter.sv
// itf_arbiter: shares one off-chip pad port among NUM_REQ requesters.
// A granted command is sent as one command beat, then the data burst runs as a
// zero-latency pass-through between the owner and the pad.
// Ports:
//   clk, rst                  : clock, async active-high reset
//   req_cmd_vld/rdy/dir/addr/num : per-requester command handshake + fields
//   req_wr_dat/vld/rdy        : per-requester write stream (chip -> off-chip)
//   rd_dat/rd_vld/rd_rdy      : shared read data, per-requester valid/ready
//   O_DatOE, O_CmdVld         : pad direction, command-beat marker
//   pad_*_out / pad_*_in      : pad drivers / receivers
//   gnt_id, busy              : current owner, transfer in progress
module itf_arbiter import itf_pkg::*; #(
  parameter  int unsigned NUM_REQ         = DEF_NUM_REQ,
  parameter  int unsigned PORT_WIDTH      = DEF_PORT_WIDTH,
  parameter  int unsigned DRAM_ADDR_WIDTH = DEF_DRAM_ADDR_WIDTH,
  parameter  int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
  localparam int unsigned IW              = idx_width(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_cmd_vld,
  output logic [NUM_REQ-1:0]              req_cmd_rdy,
  input  logic [NUM_REQ-1:0]              req_cmd_dir,
  input  logic [NUM_REQ*DRAM_ADDR_WIDTH-1:0] req_cmd_addr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_cmd_num,
  input  logic [NUM_REQ*PORT_WIDTH-1:0]   req_wr_dat,
  input  logic [NUM_REQ-1:0]              req_wr_vld,
  output logic [NUM_REQ-1:0]              req_wr_rdy,
  output logic [PORT_WIDTH-1:0]           rd_dat,
  output logic [NUM_REQ-1:0]              rd_vld,
  input  logic [NUM_REQ-1:0]              rd_rdy,
  output logic                            O_DatOE,
  output logic                            O_CmdVld,
  output logic [PORT_WIDTH-1:0]           pad_dat_out,
  output logic                            pad_vld_out,
  output logic                            pad_rdy_out,
  input  logic [PORT_WIDTH-1:0]           pad_dat_in,
  input  logic                            pad_vld_in,
  input  logic                            pad_rdy_in,
  output logic [IW-1:0]                   gnt_id,
  output logic                            busy
);

  itf_state_t r_state, w_next;

  logic [IW-1:0]              r_ptr;
  logic [IW-1:0]              r_gnt;
  logic                       r_dir;
  logic [DRAM_ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0]      r_num;
  logic [ADDR_WIDTH-1:0]      r_cnt;

  logic                       w_arb_en;
  logic [NUM_REQ-1:0]         w_arb_req;
  logic                       w_arb_vld;
  logic [NUM_REQ-1:0]         w_arb_gnt;
  logic [IW-1:0]              w_arb_idx;
  logic [IW-1:0]              w_ptr_nxt;
  logic                       w_beat;
  logic                       w_last;
  logic [PORT_WIDTH-1:0]      w_cmd_word;

  logic [DRAM_ADDR_WIDTH-1:0] w_addr_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0]      w_num_arr  [NUM_REQ];
  logic [PORT_WIDTH-1:0]      w_wdat_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr_arr[g] = req_cmd_addr[g*DRAM_ADDR_WIDTH +: DRAM_ADDR_WIDTH];
    assign w_num_arr[g]  = req_cmd_num[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdat_arr[g] = req_wr_dat[g*PORT_WIDTH +: PORT_WIDTH];
  end

  // Arbitration only in IDLE; rst masks it so nothing is acknowledged while
  // reset is held even though req_cmd_rdy is combinational.
  assign w_arb_en  = (r_state == ST_IDLE) && !rst;
  assign w_arb_req = req_cmd_vld & {NUM_REQ{w_arb_en}};

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req (w_arb_req),
    .i_ptr (r_ptr),
    .o_vld (w_arb_vld),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx)
  );

  assign w_ptr_nxt = (w_arb_idx == IW'(NUM_REQ - 1)) ? '0 : w_arb_idx + IW'(1);

  always_comb begin
    w_beat = 1'b0;
    if (r_state == ST_IN2CHIP)      w_beat = pad_vld_in & rd_rdy[r_gnt];
    else if (r_state == ST_OUT2OFF) w_beat = req_wr_vld[r_gnt] & pad_rdy_in;
  end

  assign w_last = (r_cnt == r_num - ADDR_WIDTH'(1));

  always_comb begin
    w_cmd_word                               = '0;
    w_cmd_word[DIR_BIT]                      = r_dir;
    w_cmd_word[ADDR_LSB +: DRAM_ADDR_WIDTH]  = r_addr;
    w_cmd_word[NUM_LSB +: ADDR_WIDTH]        = r_num;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        // A zero-length command is acknowledged but never reaches the pad.
        if (w_arb_vld && (w_num_arr[w_arb_idx] != '0)) w_next = ST_CMD;
      end
      ST_CMD: begin
        if (pad_rdy_in) w_next = r_dir ? ST_OUT2OFF : ST_IN2CHIP;
      end
      ST_IN2CHIP, ST_OUT2OFF: begin
        if (w_beat && w_last) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_dir   <= 1'b0;
      r_addr  <= '0;
      r_num   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_arb_vld) begin
        r_gnt  <= w_arb_idx;
        r_ptr  <= w_ptr_nxt;
        r_dir  <= req_cmd_dir[w_arb_idx];
        r_addr <= w_addr_arr[w_arb_idx];
        r_num  <= w_num_arr[w_arb_idx];
      end
      if (r_state == ST_CMD && pad_rdy_in) r_cnt <= '0;
      else if (w_beat)                     r_cnt <= r_cnt + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    req_cmd_rdy = w_arb_gnt;
    req_wr_rdy  = '0;
    rd_dat      = '0;
    rd_vld      = '0;
    O_DatOE     = 1'b0;
    O_CmdVld    = 1'b0;
    pad_dat_out = '0;
    pad_vld_out = 1'b0;
    pad_rdy_out = 1'b0;
    case (r_state)
      ST_CMD: begin
        O_CmdVld    = 1'b1;
        O_DatOE     = 1'b1;
        pad_vld_out = 1'b1;
        pad_dat_out = w_cmd_word;
      end
      ST_IN2CHIP: begin
        rd_dat        = pad_dat_in;
        rd_vld[r_gnt] = pad_vld_in;
        pad_rdy_out   = rd_rdy[r_gnt];
      end
      ST_OUT2OFF: begin
        O_DatOE           = 1'b1;
        pad_dat_out       = w_wdat_arr[r_gnt];
        pad_vld_out       = req_wr_vld[r_gnt];
        req_wr_rdy[r_gnt] = pad_rdy_in;
      end
      default: ;
    endcase
  end

  assign gnt_id = r_gnt;
  assign busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_itf_arbiter.sv
// tb_itf_arbiter: randomized scoreboard bench for itf_arbiter.
// Each round posts a set of commands; the reference model predicts grant
// order, command words and data beats into a queue that an independent
// negedge monitor consumes as the DUT produces handshakes.
module tb_itf_arbiter;
  import itf_pkg::*;

  localparam int N  = 4;
  localparam int PW = 128;
  localparam int AW = 32;
  localparam int NW = 16;

  localparam int K_GNT = 0;
  localparam int K_CMD = 1;
  localparam int K_RD  = 2;
  localparam int K_WR  = 3;

  typedef logic [PW-1:0] word_t;
  typedef struct { int kind; logic [N-1:0] vec; word_t dat; } ev_t;
  typedef struct { int id; word_t dat; } wd_t;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req_cmd_vld, req_cmd_rdy, req_cmd_dir;
  logic [N*AW-1:0] req_cmd_addr;
  logic [N*NW-1:0] req_cmd_num;
  logic [N*PW-1:0] req_wr_dat;
  logic [N-1:0]    req_wr_vld, req_wr_rdy;
  word_t           rd_dat;
  logic [N-1:0]    rd_vld, rd_rdy;
  logic            O_DatOE, O_CmdVld;
  word_t           pad_dat_out;
  logic            pad_vld_out, pad_rdy_out;
  word_t           pad_dat_in;
  logic            pad_vld_in, pad_rdy_in;
  logic [1:0]      gnt_id;
  logic            busy;

  always #5 clk = ~clk;

  itf_arbiter #(.NUM_REQ(N), .PORT_WIDTH(PW), .DRAM_ADDR_WIDTH(AW), .ADDR_WIDTH(NW)) dut (
    .clk(clk), .rst(rst),
    .req_cmd_vld(req_cmd_vld), .req_cmd_rdy(req_cmd_rdy), .req_cmd_dir(req_cmd_dir),
    .req_cmd_addr(req_cmd_addr), .req_cmd_num(req_cmd_num),
    .req_wr_dat(req_wr_dat), .req_wr_vld(req_wr_vld), .req_wr_rdy(req_wr_rdy),
    .rd_dat(rd_dat), .rd_vld(rd_vld), .rd_rdy(rd_rdy),
    .O_DatOE(O_DatOE), .O_CmdVld(O_CmdVld),
    .pad_dat_out(pad_dat_out), .pad_vld_out(pad_vld_out), .pad_rdy_out(pad_rdy_out),
    .pad_dat_in(pad_dat_in), .pad_vld_in(pad_vld_in), .pad_rdy_in(pad_rdy_in),
    .gnt_id(gnt_id), .busy(busy)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  ev_t   sb[$];
  wd_t   wq[$];
  word_t rq[$];
  logic [N-1:0]  pend;
  logic          c_dir  [N];
  logic [AW-1:0] c_addr [N];
  logic [NW-1:0] c_num  [N];
  int            mptr;
  int            p_wv, p_prdy, p_pv, p_rr;
  bit            busy_seen;

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic word_t rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  // Reference model: pending set served lowest-index-at-or-after-pointer first.
  task automatic predict(input logic [N-1:0] mask);
    logic [N-1:0] rem;
    int j;
    ev_t e;
    word_t w;
    rem = mask;
    while (rem != 0) begin
      j = -1;
      for (int k = 0; k < N; k++)
        if (j < 0 && rem[(mptr + k) % N]) j = (mptr + k) % N;
      rem[j] = 1'b0;
      mptr = (j + 1) % N;
      e.kind = K_GNT; e.vec = N'(1) << j; e.dat = '0;
      sb.push_back(e);
      if (c_num[j] != 0) begin
        e.kind = K_CMD;
        e.dat  = (word_t'(c_num[j]) << 33) | (word_t'(c_addr[j]) << 1) | word_t'(c_dir[j]);
        sb.push_back(e);
        for (int b = 0; b < int'(c_num[j]); b++) begin
          w = rnd_word();
          e.dat = w;
          if (c_dir[j]) begin
            e.kind = K_WR;
            wq.push_back('{id: j, dat: w});
          end else begin
            e.kind = K_RD;
            rq.push_back(w);
          end
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_cmd_vld[i]            = pend[i];
      req_cmd_dir[i]            = c_dir[i];
      req_cmd_addr[i*AW +: AW]  = c_addr[i];
      req_cmd_num[i*NW +: NW]   = c_num[i];
      if (wq.size() > 0 && wq[0].id == i) begin
        req_wr_vld[i]           = pct(p_wv);
        req_wr_dat[i*PW +: PW]  = wq[0].dat;
      end else begin
        req_wr_vld[i]           = 1'($urandom_range(0, 1));
        req_wr_dat[i*PW +: PW]  = rnd_word();
      end
      rd_rdy[i] = pct(p_rr);
    end
    pad_rdy_in = pct(p_prdy);
    pad_vld_in = pct(p_pv);
    pad_dat_in = (rq.size() > 0) ? rq[0] : rnd_word();
  endtask

  task automatic observe();
    logic [1:0] wid;
    pend = pend & ~(req_cmd_vld & req_cmd_rdy);
    if (wq.size() > 0) begin
      wid = 2'(wq[0].id);
      if (req_wr_vld[wid] && req_wr_rdy[wid]) void'(wq.pop_front());
    end
    if (rq.size() > 0 && pad_vld_in && pad_rdy_out) void'(rq.pop_front());
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete(); wq.delete(); rq.delete();
    pend = '0; mptr = 0;
    req_cmd_vld = '1;
    @(negedge clk);
    chk("rst_ctrl", {req_cmd_rdy, rd_vld, req_wr_rdy, O_DatOE, O_CmdVld, pad_vld_out,
                     pad_rdy_out, busy, gnt_id}, '0);
    chk("rst_pad_dat", pad_dat_out, '0);
    chk("rst_rd_dat", rd_dat, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    req_cmd_vld = '0;
    @(negedge clk);
    chk("post_rst_ctrl", {req_cmd_rdy, rd_vld, req_wr_rdy, O_DatOE, O_CmdVld, pad_vld_out,
                          pad_rdy_out, busy, gnt_id}, '0);
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_round(input logic [N-1:0] mask);
    int  cyc;
    logic done;
    pend = mask;
    predict(mask);
    drive();
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 1000) begin
      step();
      cyc++;
      done = (pend == 0) && (sb.size() == 0) && !busy;
    end
    chk("round_done", {31'd0, done}, 1);
    if (!done) do_reset();
  endtask

  // Monitor: converts DUT handshakes into events and checks them in order.
  always @(negedge clk) begin : mon
    ev_t a;
    ev_t e;
    bit  have;
    string nm;
    if (!rst) begin
      have = 1'b0;
      a.kind = 0; a.vec = '0; a.dat = '0;
      if (busy) busy_seen = 1'b1;
      if (req_cmd_rdy != 0) begin
        a.kind = K_GNT; a.vec = req_cmd_rdy; have = 1'b1;
      end else if (O_CmdVld && pad_rdy_in) begin
        a.kind = K_CMD; a.vec = N'(1) << gnt_id; a.dat = pad_dat_out; have = 1'b1;
        chk("cmd_oe", {143'd0, O_DatOE}, 1);
      end else if ((rd_vld & rd_rdy) != 0) begin
        a.kind = K_RD; a.vec = rd_vld; a.dat = rd_dat; have = 1'b1;
        chk("rd_oe", {143'd0, O_DatOE}, 0);
      end else if (O_DatOE && pad_vld_out && pad_rdy_in) begin
        a.kind = K_WR; a.vec = req_wr_rdy; a.dat = pad_dat_out; have = 1'b1;
      end
      if (!busy)
        chk("idle_quiet", {rd_vld, req_wr_rdy, pad_vld_out, pad_rdy_out, O_CmdVld, O_DatOE,
                           pad_dat_out}, '0);
      if (have) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got kind %0d vec %b dat %h, required no event",
                   a.kind, a.vec, a.dat);
        end else begin
          e = sb.pop_front();
          case (e.kind)
            K_GNT:   nm = "sb_gnt";
            K_CMD:   nm = "sb_cmd";
            K_RD:    nm = "sb_rd";
            default: nm = "sb_wr";
          endcase
          chk(nm, {4'(a.kind), a.vec, a.dat}, {4'(e.kind), e.vec, e.dat});
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int cyc;
    req_cmd_vld = '0; req_cmd_dir = '0; req_cmd_addr = '0; req_cmd_num = '0;
    req_wr_dat = '0; req_wr_vld = '0; rd_rdy = '0;
    pad_dat_in = '0; pad_vld_in = 1'b0; pad_rdy_in = 1'b0;
    for (int i = 0; i < N; i++) begin c_dir[i] = 1'b0; c_addr[i] = '0; c_num[i] = '0; end
    p_wv = 100; p_prdy = 100; p_pv = 100; p_rr = 100;
    busy_seen = 1'b0;
    do_reset();

    // Read burst from req 0.
    c_dir[0] = 1'b0; c_addr[0] = 32'h100; c_num[0] = 16'd4;
    run_round(4'b0001);

    // Write burst from req 2.
    c_dir[2] = 1'b1; c_addr[2] = 32'h20; c_num[2] = 16'd3;
    run_round(4'b0100);

    // Zero-length command: acknowledged only.
    c_dir[1] = 1'b1; c_addr[1] = 32'h55; c_num[1] = 16'd0;
    busy_seen = 1'b0;
    run_round(4'b0010);
    chk("num0_busy", {143'd0, busy_seen}, 0);

    // Read burst with randomly stalling valid/ready.
    p_pv = 50; p_rr = 50; p_prdy = 60;
    c_dir[3] = 1'b0; c_addr[3] = 32'hdead_0000; c_num[3] = 16'd5;
    run_round(4'b1000);

    // Random rounds.
    for (int r = 0; r < 40; r++) begin
      p_wv = $urandom_range(40, 100); p_prdy = $urandom_range(40, 100);
      p_pv = $urandom_range(40, 100); p_rr   = $urandom_range(40, 100);
      for (int i = 0; i < N; i++) begin
        c_dir[i]  = 1'($urandom_range(0, 1));
        c_addr[i] = $urandom();
        c_num[i]  = 16'($urandom_range(0, 6));
      end
      run_round(4'($urandom_range(1, 15)));
    end

    // Reset while the second beat of an 8-beat write is on the pad.
    p_wv = 100; p_prdy = 100; p_pv = 100; p_rr = 100;
    c_dir[1] = 1'b1; c_addr[1] = 32'h4000; c_num[1] = 16'd8;
    pend = 4'b0010;
    predict(4'b0010);
    drive();
    cyc = 0;
    while (wq.size() != 7 && cyc < 50) begin step(); cyc++; end
    chk("mid_burst_reached", 144'(wq.size()), 7);
    do_reset();

    // All four at once, twice: pointer restarts at 0 after reset and wraps.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        c_dir[i]  = 1'($urandom_range(0, 1));
        c_addr[i] = $urandom();
        c_num[i]  = 16'd1;
      end
      run_round(4'b1111);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/itf_arbiter.md
ITF_ARBITER -- requirements
Module: itf_arbiter

Interface
REQ-001 Params: NUM_REQ=4, number of requesters; PORT_WIDTH=128, off-chip word width; DRAM_ADDR_WIDTH=32, off-chip address width; ADDR_WIDTH=16, burst length width.
REQ-002 clk  in  1  single clock, all logic rising-edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req_cmd_vld / req_cmd_rdy  in/out  NUM_REQ  per-requester command handshake.
REQ-005 req_cmd_dir  in  NUM_REQ  per requester: 1 = write chip->off-chip (OUT2OFF), 0 = read off-chip->chip (IN2CHIP).
REQ-006 req_cmd_addr  in  NUM_REQ*DRAM_ADDR_WIDTH  word start address; req_cmd_num  in  NUM_REQ*ADDR_WIDTH  beat count.
REQ-007 req_wr_dat  in  NUM_REQ*PORT_WIDTH; req_wr_vld  in  NUM_REQ; req_wr_rdy  out  NUM_REQ  per-requester write stream.
REQ-008 rd_dat  out  PORT_WIDTH  shared read data; rd_vld  out  NUM_REQ; rd_rdy  in  NUM_REQ  per-requester read stream.
REQ-009 O_DatOE  out  1  1 = chip drives pad data/valid, off-chip drives ready; O_CmdVld  out  1  command beat on pad.
REQ-010 pad_dat_out  out  PORT_WIDTH; pad_vld_out  out  1; pad_rdy_out  out  1  chip-side pad drivers (tristated at pad by O_DatOE).
REQ-011 pad_dat_in  in  PORT_WIDTH; pad_vld_in  in  1; pad_rdy_in  in  1  pad receivers.
REQ-012 gnt_id  out  log2(NUM_REQ)  current owner; busy  out  1  state != IDLE.

Function
REQ-013 FSM states IDLE, CMD, IN2CHIP, OUT2OFF; one transfer owned at a time.
REQ-014 IDLE: any req_cmd_vld -> round-robin grant starting at pointer; latch dir/addr/num of winner; req_cmd_rdy[winner]=1 that cycle only (combinational with grant).
REQ-015 Pointer <= winner+1 (mod NUM_REQ) on each grant; only the winner is acknowledged in a cycle.
REQ-016 Grant with num!=0 -> CMD; num==0 -> acknowledged, stays IDLE, no pad activity.
REQ-017 CMD: O_CmdVld=1, O_DatOE=1, pad_vld_out=1, pad_dat_out = {zeros, num[ADDR_WIDTH], addr[DRAM_ADDR_WIDTH], dir} i.e. bit0=dir, bits[32:1]=addr, bits[48:33]=num; held until pad_rdy_in.
REQ-018 CMD & pad_rdy_in -> OUT2OFF if dir=1, else IN2CHIP; beat counter cleared.
REQ-019 IN2CHIP: O_DatOE=0; rd_dat=pad_dat_in; rd_vld[gnt]=pad_vld_in, others 0; pad_rdy_out=rd_rdy[gnt]; combinational pass-through, zero latency.
REQ-020 OUT2OFF: O_DatOE=1; pad_dat_out=req_wr_dat[gnt]; pad_vld_out=req_wr_vld[gnt]; req_wr_rdy[gnt]=pad_rdy_in, others 0.
REQ-021 Beat = pad valid & ready in IN2CHIP/OUT2OFF; counter increments per beat; beat with counter==num-1 -> IDLE next cycle.
REQ-022 Counter ADDR_WIDTH bits, no wrap possible (num<=2^ADDR_WIDTH-1).
REQ-023 New request arriving mid-transfer waits; held command fields change only at grant.
REQ-024 Outside active state: rd_vld=0, req_wr_rdy=0, pad_vld_out=0, pad_rdy_out=0, O_CmdVld=0; O_DatOE=0 in IDLE and IN2CHIP.

Reset
REQ-025 rst asserted at any time (incl. mid-burst): state=IDLE, counter=0, pointer=0, gnt_id=0, latched cmd=0, all outputs 0 while asserted and after release until next grant.
REQ-026 Aborted burst is not resumed; requester must reissue.

Structure
REQ-027 Shared package itf_pkg: state encoding (IDLE=0, CMD=1, IN2CHIP=2, OUT2OFF=3), command-word field offsets (DIR_BIT=0, ADDR_LSB=1, NUM_LSB=33), default width constants.
REQ-028 One sub-module: rr_arbiter (NUM_REQ request vector + pointer -> one-hot grant, index).

Verification
REQ-029 Req0 read addr=0x100 num=4, pad_rdy_in=1 -> cmd word bit0=0, [32:1]=0x100, [48:33]=4; 4 beats to rd_vld[0]; back to IDLE.
REQ-030 Req2 write addr=0x20 num=3 -> O_DatOE=1 in CMD/OUT2OFF; pad_dat_out equals req_wr_dat[2] for 3 beats; req_wr_rdy[1:0,3]=0.
REQ-031 All 4 requesters vld in same cycle, num=1 each -> grants 0,1,2,3 in order; then re-request all -> 0 again after pointer wraps from 3.
REQ-032 Read burst num=5 with pad_vld_in and rd_rdy toggled randomly -> exactly 5 beats counted, no drop/duplication.
REQ-033 num=0 request -> req_cmd_rdy pulse, O_CmdVld never asserted, busy stays 0.
REQ-034 rst pulse during beat 2 of an 8-beat write -> all outputs 0 next edge, state IDLE, pointer 0; next request granted from req 0.
